// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM walking FETCH/DECODE/EXEC/MEM/WB, driving datapath enables and muxes.
// Latency: outputs decode the registered state (FETCH irWrite/pcWrite also follow mem_ready_i); LW 5, SW/R/ADDI 4, BEQ/J 3 cycles.
// Backpressure: FETCH/MREAD/MWRITE hold until mem_ready_i, counting stall cycles. Build option ILLEGAL_TRAP_EN traps illegal opcodes.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int STALL_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OPCODE_W-1:0] ctrl_i,
    input  logic                mem_ready_i,
    output logic                memToReg_o,
    output logic                memToRead_o,
    output logic                memToWrite_o,
    output logic [ALUOP_W-1:0]  aluOp_o,
    output logic                regWrite_o,
    output logic                irWrite_o,
    output logic                pcWrite_o,
    output logic                pcWriteCond_o,
    output logic                iord_o,
    output logic                regDst_o,
    output logic                aluSrcA_o,
    output logic [1:0]          aluSrcB_o,
    output logic [1:0]          pcSrc_o,
    output logic [3:0]          state_o,
    output logic [STALL_W-1:0]  stall_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MREAD  = 4'd4,
        S_MWB    = 4'd5,
        S_MWRITE = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // Supported opcodes (IR[31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    // ALU control classes
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    // ALU B source and next-PC source encodings
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t                state_q;
    state_t                state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic [STALL_W-1:0]    stall_q;
    logic                  stall_cycle;

    // A memory-facing state waiting on the memory is a stall cycle
    assign stall_cycle = ((state_q == S_FETCH) || (state_q == S_MREAD) || (state_q == S_MWRITE))
                         && !mem_ready_i;

    // State register; reset aborts any in-flight instruction straight to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch: captured in DECODE so MADDR can pick load vs store
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= ctrl_i;
        end
    end

    // Saturating stall counter; sticks at all-ones rather than wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (stall_cycle && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (ctrl_i == OP_RTYPE) begin
                    state_d = S_REXEC;
                end else if ((ctrl_i == OP_LW) || (ctrl_i == OP_SW)) begin
                    state_d = S_MADDR;
                end else if (ctrl_i == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (ctrl_i == OP_ADDI) begin
                    state_d = S_IEXEC;
                end else if (ctrl_i == OP_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    // Unknown opcode retires as a two-cycle NOP
                    state_d = S_FETCH;
`endif
                end
            end
            S_MADDR:  state_d = (op_q == OP_LW) ? S_MREAD : S_MWRITE;
            S_MREAD:  state_d = mem_ready_i ? S_MWB : S_MREAD;
            S_MWB:    state_d = S_FETCH;
            S_MWRITE: state_d = mem_ready_i ? S_FETCH : S_MWRITE;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: everything defaults to 0, each state raises only its own controls
    always_comb begin
        memToReg_o    = 1'b0;
        memToRead_o   = 1'b0;
        memToWrite_o  = 1'b0;
        aluOp_o       = ALU_ADD;
        regWrite_o    = 1'b0;
        irWrite_o     = 1'b0;
        pcWrite_o     = 1'b0;
        pcWriteCond_o = 1'b0;
        iord_o        = 1'b0;
        regDst_o      = 1'b0;
        aluSrcA_o     = 1'b0;
        aluSrcB_o     = SRCB_RT;
        pcSrc_o       = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                // PC+4 on the ALU; IR and PC load only when the fetch lands
                memToRead_o = 1'b1;
                aluSrcB_o   = SRCB_FOUR;
                irWrite_o   = mem_ready_i;
                pcWrite_o   = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2)
                aluSrcB_o = SRCB_IMM2;
            end
            S_MADDR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = SRCB_IMM;
            end
            S_MREAD: begin
                memToRead_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_MWB: begin
                regWrite_o = 1'b1;
                memToReg_o = 1'b1;
            end
            S_MWRITE: begin
                memToWrite_o = 1'b1;
                iord_o       = 1'b1;
            end
            S_REXEC: begin
                aluSrcA_o = 1'b1;
                aluOp_o   = ALU_FUNCT;
            end
            S_RWB: begin
                regWrite_o = 1'b1;
                regDst_o   = 1'b1;
            end
            S_IEXEC: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = SRCB_IMM;
            end
            S_IWB: begin
                regWrite_o = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA_o     = 1'b1;
                aluOp_o       = ALU_SUB;
                pcWriteCond_o = 1'b1;
                pcSrc_o       = PC_ALUOUT;
            end
            S_JUMP: begin
                pcWrite_o = 1'b1;
                pcSrc_o   = PC_JUMP;
            end
            default: begin
                // IDLE and TRAP keep every control low
            end
        endcase
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: driver pushes per-cycle expectations, a negedge monitor pops and compares.
// Latency: one expectation per clock, checked half a cycle after inputs settle.
// Backpressure: mem_ready_i is driven low in FETCH/MREAD/MWRITE to exercise stalls and saturation.
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [5:0] ctrl_i;
    logic       mem_ready_i;
    logic       memToReg_o, memToRead_o, memToWrite_o;
    logic [1:0] aluOp_o;
    logic       regWrite_o, irWrite_o, pcWrite_o, pcWriteCond_o, iord_o, regDst_o, aluSrcA_o;
    logic [1:0] aluSrcB_o, pcSrc_o;
    logic [3:0] state_o;
    logic [7:0] stall_cnt_o;

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .STALL_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ctrl_i(ctrl_i), .mem_ready_i(mem_ready_i),
        .memToReg_o(memToReg_o), .memToRead_o(memToRead_o), .memToWrite_o(memToWrite_o),
        .aluOp_o(aluOp_o), .regWrite_o(regWrite_o), .irWrite_o(irWrite_o), .pcWrite_o(pcWrite_o),
        .pcWriteCond_o(pcWriteCond_o), .iord_o(iord_o), .regDst_o(regDst_o), .aluSrcA_o(aluSrcA_o),
        .aluSrcB_o(aluSrcB_o), .pcSrc_o(pcSrc_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MADDR = 4'd3, MREAD = 4'd4,
                           MWB = 4'd5, MWRITE = 4'd6, REXEC = 4'd7, RWB = 4'd8, BRANCH = 4'd9,
                           JUMP = 4'd10, IEXEC = 4'd11, IWB = 4'd12, TRAP = 4'd13;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] outs;
        logic [7:0]  sc;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stall_model = 0;
    logic [15:0] act_outs;

    // {memToReg, memToRead, memToWrite, aluOp[1:0], regWrite, irWrite, pcWrite,
    //  pcWriteCond, iord, regDst, aluSrcA, aluSrcB[1:0], pcSrc[1:0]}
    assign act_outs = {memToReg_o, memToRead_o, memToWrite_o, aluOp_o, regWrite_o, irWrite_o,
                       pcWrite_o, pcWriteCond_o, iord_o, regDst_o, aluSrcA_o, aluSrcB_o, pcSrc_o};

    // Hand-written control table per state
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rdy);
        logic m2r, rd, wr, rw, ir, pcw, pcc, iord, rdst, sa;
        logic [1:0] aop, sb, ps;
        {m2r, rd, wr, rw, ir, pcw, pcc, iord, rdst, sa} = '0;
        aop = 2'b00; sb = 2'b00; ps = 2'b00;
        case (st)
            FETCH:  begin rd = 1; sb = 2'b01; ir = rdy; pcw = rdy; end
            DECODE: begin sb = 2'b11; end
            MADDR:  begin sa = 1; sb = 2'b10; end
            MREAD:  begin rd = 1; iord = 1; end
            MWB:    begin rw = 1; m2r = 1; end
            MWRITE: begin wr = 1; iord = 1; end
            REXEC:  begin sa = 1; aop = 2'b10; end
            RWB:    begin rw = 1; rdst = 1; end
            IEXEC:  begin sa = 1; sb = 2'b10; end
            IWB:    begin rw = 1; end
            BRANCH: begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; end
            JUMP:   begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {m2r, rd, wr, aop, rw, ir, pcw, pcc, iord, rdst, sa, sb, ps};
    endfunction

    // One clock: drive inputs after the edge and queue what the DUT must show this cycle
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy, input logic [3:0] st);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_ni      = rst;
        ctrl_i      = op;
        mem_ready_i = rdy;
        if (!rst) stall_model = 0;
        e.st   = st;
        e.outs = exp_outs(st, rdy);
        e.sc   = 8'(stall_model);
        e.idx  = cyc;
        q.push_back(e);
        cyc++;
        if (rst && (st == FETCH || st == MREAD || st == MWRITE) && !rdy && stall_model < 255)
            stall_model++;
    endtask

    task automatic fetch(input logic rdy);
        step(1'b1, 6'b0, rdy, FETCH);
    endtask

    // Monitor: pops one expectation per clock and compares away from the active edge
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (state_o !== e.st) begin
                errors++;
                $display("FAIL state cyc=%0d got=%0d want=%0d", e.idx, state_o, e.st);
            end
            tests++;
            if (act_outs !== e.outs) begin
                errors++;
                $display("FAIL outputs cyc=%0d state=%0d got=%b want=%b", e.idx, state_o, act_outs, e.outs);
            end
            tests++;
            if (stall_cnt_o !== e.sc) begin
                errors++;
                $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.idx, stall_cnt_o, e.sc);
            end
            tests++;
            if (memToRead_o && memToWrite_o) begin
                errors++;
                $display("FAIL rd_wr_exclusive cyc=%0d got=11 want=not both", e.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; ctrl_i = '0; mem_ready_i = 1'b1;
        // Reset state, then release: IDLE for one cycle, then FETCH
        step(1'b0, 6'b0, 1'b1, IDLE);
        step(1'b0, 6'b0, 1'b1, IDLE);
        step(1'b1, 6'b0, 1'b1, IDLE);

        // R-type
        fetch(1'b1);
        step(1'b1, 6'b000000, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, REXEC);
        step(1'b1, 6'b0, 1'b1, RWB);

        // LW with three wait cycles in MREAD
        fetch(1'b1);
        step(1'b1, 6'b100011, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, MADDR);
        for (int i = 0; i < 3; i++) step(1'b1, 6'b0, 1'b0, MREAD);
        step(1'b1, 6'b0, 1'b1, MREAD);
        step(1'b1, 6'b0, 1'b1, MWB);

        // SW
        fetch(1'b1);
        step(1'b1, 6'b101011, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, MADDR);
        step(1'b1, 6'b0, 1'b1, MWRITE);

        // BEQ, ADDI, J
        fetch(1'b1);
        step(1'b1, 6'b000100, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, BRANCH);
        fetch(1'b1);
        step(1'b1, 6'b001000, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, IEXEC);
        step(1'b1, 6'b0, 1'b1, IWB);
        fetch(1'b1);
        step(1'b1, 6'b000010, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, JUMP);

        // Long fetch stall: counter must stick at 255
        for (int i = 0; i < 300; i++) fetch(1'b0);
        fetch(1'b1);

        // SW interrupted by reset in MWRITE
        step(1'b1, 6'b101011, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, MADDR);
        step(1'b1, 6'b0, 1'b0, MWRITE);
        step(1'b0, 6'b0, 1'b0, IDLE);
        step(1'b1, 6'b0, 1'b1, IDLE);
        fetch(1'b1);

        // Illegal opcode
        step(1'b1, 6'b111111, 1'b1, DECODE);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) step(1'b1, 6'b0, 1'b1, TRAP);
`else
        fetch(1'b1);
        step(1'b1, 6'b000010, 1'b1, DECODE);
        step(1'b1, 6'b0, 1'b1, JUMP);
`endif
        // Final reset pulse and restart
        step(1'b0, 6'b0, 1'b1, IDLE);
        step(1'b1, 6'b0, 1'b1, IDLE);
        fetch(1'b1);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk_i);
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
